cluster_dbg_halt_ctrl: RTL and testbench

//   Per-core debug halt/resume handshake engine, directly downstream of the cluster control unit.

---
 rtl/cluster_dbg_halt_ctrl.sv | 111 +++++++++++
 tb/tb_cluster_dbg_halt_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/cluster_dbg_halt_ctrl.sv
// Per-core debug halt/resume handshake engine.
// Widens single-cycle halt/resume pulses from the cluster control unit into
// level debug/resume requests. Each request is held until the core acknowledges
// through debug_mode_i, or until a bounded wait expires. Reports per-core halted
// status and a sticky timeout flag.
module cluster_dbg_halt_ctrl #(
  parameter int unsigned NB_CORES       = 4,
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned CNT_WIDTH      = 9
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NB_CORES-1:0] halt_i,
  input  logic [NB_CORES-1:0] resume_i,
  input  logic [NB_CORES-1:0] debug_mode_i,
  input  logic [NB_CORES-1:0] clr_timeout_i,
  output logic [NB_CORES-1:0] dbg_req_o,
  output logic [NB_CORES-1:0] resume_req_o,
  output logic [NB_CORES-1:0] halted_o,
  output logic [NB_CORES-1:0] timeout_o,
  output logic                any_halted_o
);

  // Each request output is one bit of the state encoding, so all outputs are
  // plain register bits with no decode logic.
  typedef enum logic [2:0] {
    S_RUN        = 3'b000,
    S_HALT_REQ   = 3'b001,
    S_HALTED     = 3'b010,
    S_RESUME_REQ = 3'b100
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX =
    (TIMEOUT_CYCLES == 0) ? '0 : CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  for (genvar c = 0; c < NB_CORES; c++) begin : g_core
    state_t               state;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 dm_q;
    logic                 tmo_q;
    logic                 expired;

    assign expired = (TIMEOUT_CYCLES != 0) && (cnt == CNT_MAX);

    // Handshake FSM for this core. Acknowledge beats abort, and abort beats
    // timeout. A timeout set overrides a clear arriving in the same cycle.
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        state <= S_RUN;
        cnt   <= '0;
        dm_q  <= 1'b0;
        tmo_q <= 1'b0;
      end else begin
        dm_q <= debug_mode_i[c];
        if (clr_timeout_i[c]) tmo_q <= 1'b0;
        case (state)
          S_RUN: begin
            if (debug_mode_i[c]) begin
              state <= S_HALTED;
            end else if (halt_i[c]) begin
              state <= S_HALT_REQ;
              cnt   <= '0;
            end
          end
          S_HALT_REQ: begin
            if (debug_mode_i[c]) begin
              state <= S_HALTED;
            end else if (resume_i[c]) begin
              state <= S_RUN;
            end else if (expired) begin
              state <= S_RUN;
              tmo_q <= 1'b1;
            end else if (TIMEOUT_CYCLES != 0) begin
              cnt <= cnt + 1'b1;
            end
          end
          S_HALTED: begin
            if (resume_i[c]) begin
              state <= S_RESUME_REQ;
              cnt   <= '0;
            end else if (dm_q && !debug_mode_i[c]) begin
              state <= S_RUN;
            end
          end
          S_RESUME_REQ: begin
            if (!debug_mode_i[c]) begin
              state <= S_RUN;
            end else if (expired) begin
              state <= S_HALTED;
              tmo_q <= 1'b1;
            end else if (TIMEOUT_CYCLES != 0) begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state <= S_RUN;
            cnt   <= '0;
          end
        endcase
      end
    end

    assign dbg_req_o[c]    = state[0];
    assign halted_o[c]     = state[1];
    assign resume_req_o[c] = state[2];
    assign timeout_o[c]    = tmo_q;
  end

  assign any_halted_o = |halted_o;

endmodule

// File: tb/tb_cluster_dbg_halt_ctrl.sv
// Directed self-checking bench for cluster_dbg_halt_ctrl (TIMEOUT_CYCLES=8).
module tb_cluster_dbg_halt_ctrl;

  logic       clk;
  logic       rst_n;
  logic [3:0] halt;
  logic [3:0] resume;
  logic [3:0] dm;
  logic [3:0] clr;
  logic [3:0] dbg_req;
  logic [3:0] resume_req;
  logic [3:0] halted;
  logic [3:0] timeout;
  logic       any_halted;

  int checks = 0;
  int errors = 0;

  cluster_dbg_halt_ctrl #(
    .NB_CORES      (4),
    .TIMEOUT_CYCLES(8),
    .CNT_WIDTH     (4)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .halt_i       (halt),
    .resume_i     (resume),
    .debug_mode_i (dm),
    .clr_timeout_i(clr),
    .dbg_req_o    (dbg_req),
    .resume_req_o (resume_req),
    .halted_o     (halted),
    .timeout_o    (timeout),
    .any_halted_o (any_halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; halt = '0; resume = '0; dm = '0; clr = '0;

    // Reset state
    tick(); tick();
    check("rst_dbg_req", dbg_req, 4'b0000);
    check("rst_resume_req", resume_req, 4'b0000);
    check("rst_halted", halted, 4'b0000);
    check("rst_timeout", timeout, 4'b0000);
    check("rst_any", {3'b000, any_halted}, 4'b0000);
    rst_n = 1'b1;
    tick();

    // T1: halt with ack at t0+3
    halt = 4'b0010; tick();
    halt = '0;
    check("t1_dbg_t1", dbg_req, 4'b0010);
    tick();
    check("t1_dbg_t2", dbg_req, 4'b0010);
    tick();
    check("t1_dbg_t3", dbg_req, 4'b0010);
    dm[1] = 1'b1; tick();
    check("t1_halted", halted, 4'b0010);
    check("t1_dbg_off", dbg_req, 4'b0000);
    check("t1_any", {3'b000, any_halted}, 4'b0001);

    // T2: resume, core leaves debug two cycles later
    resume = 4'b0010; tick();
    resume = '0;
    check("t2_rreq_t1", resume_req, 4'b0010);
    check("t2_halted_off", halted, 4'b0000);
    check("t2_any_off", {3'b000, any_halted}, 4'b0000);
    tick();
    check("t2_rreq_t2", resume_req, 4'b0010);
    dm[1] = 1'b0; tick();
    check("t2_rreq_off", resume_req, 4'b0000);
    check("t2_halted_run", halted, 4'b0000);

    // T3: halt timeout, request held exactly 8 cycles
    halt = 4'b0001; tick();
    halt = '0;
    check("t3_dbg_c1", dbg_req, 4'b0001);
    for (int i = 2; i <= 8; i++) begin
      tick();
      check($sformatf("t3_dbg_c%0d", i), dbg_req, 4'b0001);
    end
    tick();
    check("t3_dbg_dropped", dbg_req, 4'b0000);
    check("t3_timeout_set", timeout, 4'b0001);
    tick(); tick();
    check("t3_timeout_sticky", timeout, 4'b0001);
    clr = 4'b0001; tick();
    clr = '0;
    check("t3_timeout_clr", timeout, 4'b0000);
    // Second timeout lands on the same edge as a clear: set wins
    halt = 4'b0001; tick();
    halt = '0;
    for (int i = 2; i <= 8; i++) tick();
    check("t3b_dbg_c8", dbg_req, 4'b0001);
    clr = 4'b0001; tick();
    clr = '0;
    check("t3b_set_wins", timeout, 4'b0001);
    check("t3b_dbg_dropped", dbg_req, 4'b0000);
    clr = 4'b0001; tick();
    clr = '0;
    check("t3b_timeout_clr", timeout, 4'b0000);

    // T4: breakpoint entry without halt request
    dm[3] = 1'b1; tick();
    check("t4_halted", halted, 4'b1000);
    check("t4_no_dbg", dbg_req, 4'b0000);
    tick();
    check("t4_no_dbg_hold", dbg_req, 4'b0000);
    dm[3] = 1'b0; tick();
    check("t4_self_exit", halted, 4'b0000);
    check("t4_no_rreq", resume_req, 4'b0000);

    // T5: abort two cycles after halt
    halt = 4'b0100; tick();
    halt = '0;
    check("t5_dbg", dbg_req, 4'b0100);
    tick();
    resume = 4'b0100; tick();
    resume = '0;
    check("t5_abort_dbg", dbg_req, 4'b0000);
    check("t5_abort_rreq", resume_req, 4'b0000);
    for (int i = 0; i < 10; i++) tick();
    check("t5_no_timeout", timeout, 4'b0000);
    check("t5_still_run", halted | dbg_req, 4'b0000);
    // halt_i while HALTED is ignored
    dm[2] = 1'b1; tick();
    check("t5_halted", halted, 4'b0100);
    halt = 4'b0100; tick();
    halt = '0;
    check("t5_halt_ignored", halted, 4'b0100);
    check("t5_halt_ignored_dbg", dbg_req, 4'b0000);
    dm[2] = 1'b0; tick();
    check("t5_exit", halted, 4'b0000);

    // RUN: halt and debug mode together go straight to HALTED
    halt = 4'b0010; dm[1] = 1'b1; tick();
    halt = '0;
    check("prec_run_halted", halted, 4'b0010);
    check("prec_run_no_dbg", dbg_req, 4'b0000);
    dm[1] = 1'b0; tick();
    check("prec_run_exit", halted, 4'b0000);

    // HALT_REQ: ack beats abort
    halt = 4'b0001; tick();
    halt = '0;
    dm[0] = 1'b1; resume = 4'b0001; tick();
    resume = '0;
    check("prec_ack_halted", halted, 4'b0001);
    check("prec_ack_no_rreq", resume_req, 4'b0000);
    dm[0] = 1'b0; tick();
    check("prec_ack_exit", halted, 4'b0000);

    // RESUME_REQ timeout returns to HALTED with the flag set
    dm[0] = 1'b1; tick();
    resume = 4'b0001; tick();
    resume = '0;
    check("rto_rreq_c1", resume_req, 4'b0001);
    for (int i = 2; i <= 8; i++) tick();
    check("rto_rreq_c8", resume_req, 4'b0001);
    tick();
    check("rto_rreq_dropped", resume_req, 4'b0000);
    check("rto_halted", halted, 4'b0001);
    check("rto_timeout", timeout, 4'b0001);
    dm[0] = 1'b0; tick();
    check("rto_exit", halted, 4'b0000);
    check("rto_timeout_sticky", timeout, 4'b0001);

    // T6: synchronous reset in the middle of HALT_REQ on every core
    halt = 4'b1111; tick();
    halt = '0;
    check("t6_dbg_all", dbg_req, 4'b1111);
    rst_n = 1'b0; #2;
    check("t6_pre_edge_dbg", dbg_req, 4'b1111);
    check("t6_pre_edge_tmo", timeout, 4'b0001);
    tick();
    check("t6_rst_dbg", dbg_req, 4'b0000);
    check("t6_rst_halted", halted, 4'b0000);
    check("t6_rst_timeout", timeout, 4'b0000);
    rst_n = 1'b1; tick();
    check("t6_post_rst_dbg", dbg_req, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
